timer_share_ctrl: RTL

- Shares one 64-bit interval-timer slave (16-bit halfword register map) among N one-shot timeout requesters.
- Round-robin arbitration between requesters. The winner's period is programmed through the timer's write port, the timer is started in one-shot mode with interrupt enabled, and the block waits for the timer irq.
- On expiry it clears the timer status and pulses done to the owner.
- Sits between accelerator/driver logic and the timer instance; replaces software servicing of the timer.

---
 rtl/timer_share_pkg.sv | 34 +++
 rtl/rr_arbiter_n.sv | 28 ++
 rtl/timer_share_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/timer_share_pkg.sv
// Shared constants and FSM state type for the timer sharing controller.
package timer_share_pkg;

   // Timer slave word addresses
   localparam logic [3:0] ADDR_STATUS  = 4'd0;
   localparam logic [3:0] ADDR_CONTROL = 4'd1;
   localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
   localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
   localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
   localparam logic [3:0] ADDR_PERIOD3 = 4'd5;

   // Control register bit masks
   localparam logic [15:0] CTL_ITO   = 16'h0001;
   localparam logic [15:0] CTL_CONT  = 16'h0002;
   localparam logic [15:0] CTL_START = 16'h0004;
   localparam logic [15:0] CTL_STOP  = 16'h0008;

   // One-shot start with interrupt enabled (continuous bit deliberately clear)
   localparam logic [15:0] CTL_WORD_START = CTL_START | CTL_ITO;
   localparam logic [15:0] CTL_WORD_STOP  = CTL_STOP;

   typedef enum logic [3:0] {
      StIdle,
      StP0,
      StP1,
      StP2,
      StP3,
      StStart,
      StWait,
      StStop,
      StAck
   } state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter_n #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [PW-1:0] idx;

   // Scan N positions starting at ptr; the first hit wins
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = PW'((32'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_share_ctrl.sv
// Shares one interval timer among N one-shot timeout requesters.
module timer_share_ctrl
   import timer_share_pkg::*;
#(
   parameter int unsigned N_CLIENTS = 4,
   parameter int unsigned PERIOD_W  = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_CLIENTS-1:0]          req,
   input  logic [N_CLIENTS*PERIOD_W-1:0] req_period,
   input  logic [N_CLIENTS-1:0]          abort,
   output logic [N_CLIENTS-1:0]          grant,
   output logic [N_CLIENTS-1:0]          done,
   output logic                          done_aborted,
   output logic                          busy,
   output logic [3:0]                    tm_address,
   output logic                          tm_chipselect,
   output logic                          tm_write_n,
   output logic [15:0]                   tm_writedata,
   input  logic                          tm_irq
);

   localparam int unsigned OW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

   state_e               state_q, state_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PERIOD_W-1:0]  period_q, period_d;
   logic                 aborted_q, aborted_d;

   logic [N_CLIENTS-1:0] win_oh;
   logic                 win_valid;
   logic [OW-1:0]        win_idx;
   logic [PERIOD_W-1:0]  win_period;

   logic [N_CLIENTS-1:0] grant_d, done_d;
   logic                 done_aborted_d;
   logic                 cs_d;
   logic [3:0]           addr_d;
   logic [15:0]          wdata_d;

   rr_arbiter_n #(
      .N  (N_CLIENTS),
      .PW (OW)
   ) u_arb (
      .req    (req),
      .ptr    (rr_ptr_q),
      .winner (win_oh),
      .valid  (win_valid)
   );

   // Encode the one-hot winner and select its period; a zero load would fire at once
   always_comb begin
      win_idx    = '0;
      win_period = '0;
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
         if (win_oh[i]) begin
            win_idx    = OW'(i);
            win_period = req_period[i*PERIOD_W +: PERIOD_W];
         end
      end
      if (win_period == '0) begin
         win_period = PERIOD_W'(1);
      end
   end

   // Next-state logic for the job sequencer
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      period_d  = period_q;
      aborted_d = aborted_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = '0;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               owner_d   = win_idx;
               period_d  = win_period;
               aborted_d = 1'b0;
               grant_d   = win_oh;
               state_d   = StP0;
            end
         end
         StP0:    state_d = StP1;
         StP1:    state_d = StP2;
         StP2:    state_d = StP3;
         StP3:    state_d = StStart;
         StStart: state_d = StWait;
         StWait: begin
            // Expiry takes priority over a simultaneous abort
            if (tm_irq) begin
               aborted_d = 1'b0;
               state_d   = StAck;
            end else if (abort[owner_q]) begin
               aborted_d = 1'b1;
               state_d   = StStop;
            end
         end
         StStop: state_d = StAck;
         StAck: begin
            rr_ptr_d = (owner_q == OW'(N_CLIENTS - 1)) ? '0 : owner_q + OW'(1);
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output values decoded from the next state so registered outputs line up with the state
   always_comb begin
      cs_d           = 1'b0;
      addr_d         = ADDR_STATUS;
      wdata_d        = 16'h0000;
      done_d         = '0;
      done_aborted_d = 1'b0;
      unique case (state_d)
         StP0: begin
            cs_d    = 1'b1;
            addr_d  = ADDR_PERIOD0;
            wdata_d = period_d[15:0];
         end
         StP1: begin
            cs_d    = 1'b1;
            addr_d  = ADDR_PERIOD1;
            wdata_d = period_d[31:16];
         end
         StP2: begin
            cs_d    = 1'b1;
            addr_d  = ADDR_PERIOD2;
            wdata_d = period_d[47:32];
         end
         StP3: begin
            cs_d    = 1'b1;
            addr_d  = ADDR_PERIOD3;
            wdata_d = period_d[63:48];
         end
         StStart: begin
            cs_d    = 1'b1;
            addr_d  = ADDR_CONTROL;
            wdata_d = CTL_WORD_START;
         end
         StStop: begin
            cs_d    = 1'b1;
            addr_d  = ADDR_CONTROL;
            wdata_d = CTL_WORD_STOP;
         end
         StAck: begin
            cs_d            = 1'b1;
            addr_d          = ADDR_STATUS;
            wdata_d         = 16'h0000;
            done_d[owner_d] = 1'b1;
            done_aborted_d  = aborted_d;
         end
         default: ;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         period_q      <= '0;
         aborted_q     <= 1'b0;
         grant         <= '0;
         done          <= '0;
         done_aborted  <= 1'b0;
         tm_chipselect <= 1'b0;
         tm_write_n    <= 1'b1;
         tm_address    <= '0;
         tm_writedata  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         period_q      <= period_d;
         aborted_q     <= aborted_d;
         grant         <= grant_d;
         done          <= done_d;
         done_aborted  <= done_aborted_d;
         tm_chipselect <= cs_d;
         tm_write_n    <= ~cs_d;
         tm_address    <= addr_d;
         tm_writedata  <= wdata_d;
      end
   end

   assign busy = (state_q != StIdle);

endmodule
